// File: rtl/layer_compositor_pkg.sv
// Shared constants and helpers for the layer compositor: pixel width,
// colour-key default, index widths and {R,G,B} channel positions.
package layer_compositor_pkg;

  localparam int R_CH = 2;
  localparam int G_CH = 1;
  localparam int B_CH = 0;

  // Default colour key is all-zero; replicated to the pixel width by users.
  localparam logic TRANSPARENT_BIT = 1'b0;

  function automatic int color_w(input int ch_w);
    return 3 * ch_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_compositor_priority_sel.sv
// Combinational priority picker: lowest opaque layer wins; also flags
// when two or more masked layers are opaque on the same pixel.
module layer_priority_sel
  import layer_compositor_pkg::*;
#(
  parameter int                    NUM_LAYERS   = 3,
  parameter int                    COLOR_W      = 12,
  parameter logic [NUM_LAYERS-1:0] OVERLAP_MASK = '1
)(
  input  logic [NUM_LAYERS-1:0]         i_opaque,
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_pix,
  output logic [COLOR_W-1:0]            o_color,
  output logic                          o_valid,
  output logic                          o_multi
);

  localparam int IW = idx_w(NUM_LAYERS);

  logic [IW-1:0]         w_idx;
  logic [NUM_LAYERS-1:0] w_masked;
  logic                  w_seen;

  assign w_masked = i_opaque & OVERLAP_MASK;

  // Scan high to low so the last write is the highest-priority layer.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (i_opaque[i]) w_idx = IW'(i);
  end

  always_comb begin
    w_seen  = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_masked[i]) begin
        if (w_seen) o_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  assign o_valid = |i_opaque;
  assign o_color = i_pix[w_idx*COLOR_W +: COLOR_W];

endmodule

// File: rtl/layer_compositor.sv
// Layer compositor: colour-keyed priority mux over NUM_LAYERS sources with
// enables, frame blinking, per-frame overlap flag and a 2-stage video pipe.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int                    NUM_LAYERS   = 3,
  parameter int                    CH_W         = 4,
  parameter logic [3*CH_W-1:0]     TRANSPARENT  = {(3*CH_W){TRANSPARENT_BIT}},
  parameter int                    BLINK_FRAMES = 30,
  parameter logic [NUM_LAYERS-1:0] OVERLAP_MASK = '1,
  parameter logic                  SYNC_IDLE    = 1'b1
)(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_LAYERS*color_w(CH_W)-1:0]   layer_pix,
  input  logic [NUM_LAYERS-1:0]                 layer_en,
  input  logic [NUM_LAYERS-1:0]                 layer_blink,
  input  logic [color_w(CH_W)-1:0]              bg_color,
  input  logic                                  video_on,
  input  logic                                  hsync_in,
  input  logic                                  vsync_in,
  input  logic                                  frame_tick,
  output logic [CH_W-1:0]                       VGA_R,
  output logic [CH_W-1:0]                       VGA_G,
  output logic [CH_W-1:0]                       VGA_B,
  output logic                                  hsync_out,
  output logic                                  vsync_out,
  output logic                                  video_on_out,
  output logic                                  overlap,
  output logic                                  blink_phase
);

  localparam int COLOR_W = color_w(CH_W);
  localparam int CW      = idx_w(BLINK_FRAMES);

  logic [NUM_LAYERS-1:0] w_opaque;
  logic [COLOR_W-1:0]    w_lay_color;
  logic                  w_valid;
  logic                  w_multi;

  logic [CW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_overlap;

  logic [COLOR_W-1:0]    r_color1;
  logic                  r_vid1, r_hs1, r_vs1, r_hit1;
  logic [COLOR_W-1:0]    r_rgb2;
  logic                  r_vid2, r_hs2, r_vs2;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    assign w_opaque[g] = layer_en[g] & ~(layer_blink[g] & r_blink_phase) &
                         (layer_pix[g*COLOR_W +: COLOR_W] != TRANSPARENT);
  end

  layer_priority_sel #(
    .NUM_LAYERS   (NUM_LAYERS),
    .COLOR_W      (COLOR_W),
    .OVERLAP_MASK (OVERLAP_MASK)
  ) u_sel (
    .i_opaque (w_opaque),
    .i_pix    (layer_pix),
    .o_color  (w_lay_color),
    .o_valid  (w_valid),
    .o_multi  (w_multi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Syncs reset to their idle level so no spurious pulse leaves the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_color1 <= '0;
      r_vid1   <= 1'b0;
      r_hs1    <= SYNC_IDLE;
      r_vs1    <= SYNC_IDLE;
      r_hit1   <= 1'b0;
      r_rgb2   <= '0;
      r_vid2   <= 1'b0;
      r_hs2    <= SYNC_IDLE;
      r_vs2    <= SYNC_IDLE;
    end else begin
      r_color1 <= w_valid ? w_lay_color : bg_color;
      r_vid1   <= video_on;
      r_hs1    <= hsync_in;
      r_vs1    <= vsync_in;
      r_hit1   <= video_on & w_multi;
      r_rgb2   <= r_vid1 ? r_color1 : '0;
      r_vid2   <= r_vid1;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
    end
  end

  // frame_tick restarts the flag but keeps a hit landing on the same cycle.
  always_ff @(posedge clk) begin
    if (reset)           r_overlap <= 1'b0;
    else if (frame_tick) r_overlap <= r_hit1;
    else                 r_overlap <= r_overlap | r_hit1;
  end

  assign VGA_R        = r_rgb2[R_CH*CH_W +: CH_W];
  assign VGA_G        = r_rgb2[G_CH*CH_W +: CH_W];
  assign VGA_B        = r_rgb2[B_CH*CH_W +: CH_W];
  assign hsync_out    = r_hs2;
  assign vsync_out    = r_vs2;
  assign video_on_out = r_vid2;
  assign overlap      = r_overlap;
  assign blink_phase  = r_blink_phase;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor of the fixed three-input colorizer: selects one of NUM_LAYERS pixel layers per pixel, using a transparent colour key and fixed priority (layer 0 on top).
- Adds per-layer enables, frame-synchronous blinking, a per-frame overlap detector and a registered two-stage pipeline that delays sync and blanking with the pixel data.
- Sits between the layer pixel sources (title, icon, map, ...) and the VGA pins.

Parameters:
- NUM_LAYERS, 3, number of input layers; index 0 has highest priority.
- CH_W, 4, bits per colour channel; the pixel width is COLOR_W = 3*CH_W ordered {R,G,B}.
- TRANSPARENT, 0, colour value meaning "no pixel" on any layer.
- BLINK_FRAMES, 30, frame_tick pulses per blink half-period; must be at least 1.
- OVERLAP_MASK, all ones, layers that take part in overlap detection.
- SYNC_IDLE, 1'b1, reset and idle level of hsync_out and vsync_out.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- layer_pix  in  NUM_LAYERS*COLOR_W  packed layer pixels; layer i occupies bits [i*COLOR_W +: COLOR_W]
- layer_en  in  NUM_LAYERS  per-layer enable
- layer_blink  in  NUM_LAYERS  per-layer blink enable
- bg_color  in  COLOR_W  colour shown when no layer is opaque
- video_on  in  1  active display region
- hsync_in  in  1  horizontal sync, aligned with the pixel inputs
- vsync_in  in  1  vertical sync, aligned with the pixel inputs
- frame_tick  in  1  one-cycle pulse once per frame
- VGA_R  out  CH_W  red channel, registered
- VGA_G  out  CH_W  green channel, registered
- VGA_B  out  CH_W  blue channel, registered
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles
- video_on_out  out  1  video_on delayed 2 cycles
- overlap  out  1  sticky per-frame overlap flag
- blink_phase  out  1  current blink phase; 1 = blinking layers hidden

Behaviour:
- The interface has one clock, clk. reset is synchronous and active-high.
- On reset:
  - VGA_R, VGA_G, VGA_B = 0.
  - hsync_out and vsync_out = SYNC_IDLE.
  - video_on_out, overlap and blink_phase = 0.
  - Blink counter = 0 and all pipeline registers cleared.
- A reset asserted mid-frame takes effect on the next edge. The pipeline restarts cleanly and produces no partial pixel.
- Stage 1 (edge N), computes and registers:
  - opaque[i] = layer_en[i] & ~(layer_blink[i] & blink_phase) & (pix_i != TRANSPARENT).
  - The selected colour: pix of the lowest index i with opaque[i]; bg_color if no layer is opaque.
  - hit = video_on & (popcount(opaque & OVERLAP_MASK) >= 2).
  - video_on, hsync_in and vsync_in, delayed with the data.
- Stage 2 (edge N+1):
  - {VGA_R,VGA_G,VGA_B} = stage-1 video_on ? selected colour : 0.
  - Syncs and video_on_out forwarded.
  - Total latency is exactly 2 cycles for every output except overlap and blink_phase.
- Blink:
  - A counter 0..BLINK_FRAMES-1 advances on frame_tick.
  - On frame_tick with the counter at BLINK_FRAMES-1: the counter wraps to 0 and blink_phase toggles.
  - With BLINK_FRAMES=1, blink_phase toggles every frame_tick.
  - A new phase affects stage 1 from the cycle after the tick.
- Overlap:
  - Without frame_tick: overlap <= overlap | stage-1 hit.
  - On frame_tick: overlap <= stage-1 hit. The frame_tick clear wins, but a hit in the same cycle is kept as the first hit of the new frame.
- All layers disabled or transparent: output is bg_color while video_on, otherwise 0.
- bg_color equal to TRANSPARENT is legal and is output unchanged.
- Changes to layer_en and layer_blink apply on the pixel sampled that cycle; there is no frame-boundary shadowing.

Decomposition:
- Shared package: COLOR_W derivation, a TRANSPARENT default constant, a layer index width function (clog2 of NUM_LAYERS), and {R,G,B} channel slice constants.
- One sub-module, layer_priority_sel:
  - Combinational.
  - Takes the opaque vector and packed pixels.
  - Returns the selected colour, a valid bit and the overlap hit.
- The blink counter, pipeline registers and overlap flag stay in the top module.

Test Plan:
- Priority: NUM_LAYERS=3, all enabled, layer_pix = {12'h00F, 12'hF00, 12'h0F0}, video_on=1 → 2 cycles later RGB = 0,F,0 (layer 0 wins); then set layer0 = 0 → RGB = F,0,0.
- Blanking/latency: a pixel stream with a single video_on=0 cycle and a hsync pulse → RGB=0, video_on_out=0 and hsync_out all delayed exactly 2 cycles and aligned; bg_color=12'h123 with no opaque layer → 1,2,3.
- Blink: BLINK_FRAMES=2, layer_blink=3'b001, layer0=12'hFFF, layer1=12'h00F → output FFF for 2 ticks, 00F for the next 2, back to FFF; blink_phase toggles on the 2nd and 4th tick.
- Overlap: layers 0 and 1 opaque for one video_on pixel → overlap=1 from 2 cycles later, held to the next frame_tick, then 0; repeat with the hit on the frame_tick cycle → overlap stays 1.
- Enable: layer_en=3'b110 with layer0 opaque → layer1 colour shown; the hit is ignored when OVERLAP_MASK excludes layer1.
- Reset mid-frame: reset asserted for 1 cycle during active video → next cycle RGB=0, syncs=SYNC_IDLE, overlap=0, blink counter restarts (phase toggles only after BLINK_FRAMES ticks).
